plot_framebuffer: RTL and testbench
===================================

# plot_framebuffer

Receiving end of the pixel-plot interface driven by the fractal and drawing engines. It accepts `vga_x`/`vga_y`/`vga_colour`/`vga_plot` writes into an on-chip 160×120×3-bit frame store. It also scans the store out continuously in raster order with sync timing for the display path. A clear sequencer blanks the store on request.

## Interface
**Parameters**
- `WIDTH`, default 160: active columns.
- `HEIGHT`, default 120: active rows.
- `H_TOTAL`, default 200: pixel ticks per line.
- `V_TOTAL`, default 131: lines per frame.
- `H_SYNC_START`, default 170: first `h` with hsync asserted.
- `H_SYNC_LEN`, default 12: hsync width in ticks.
- `V_SYNC_START`, default 122: first `v` with vsync asserted.
- `V_SYNC_LEN`, default 2: vsync width in lines.
- `PIX_DIV`, default 4: clk cycles per pixel tick (≥2).

**Ports**
- `clk` in 1: single clock; everything is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `vga_x` in 8: plot column.
- `vga_y` in 7: plot row.
- `vga_colour` in 3: plot colour.
- `vga_plot` in 1: write strobe, one write per cycle high.
- `clear` in 1: request a store clear (level sampled per cycle).
- `busy` out 1: high while a clear is in progress.
- `drop_count` out 16: count of rejected plots, saturating at 0xFFFF.
- `pix_x` out 8, `pix_y` out 7: scan position of the presented pixel.
- `pix_colour` out 3: stored colour; 0 when not active.
- `pix_active` out 1: presented pixel is inside WIDTH×HEIGHT.
- `hsync_n` out 1, `vsync_n` out 1: active-low syncs.
- `frame_start` out 1: one-cycle pulse with pixel (0,0).

## Operation
- **Store:** WIDTH·HEIGHT entries × 3 bits, address `y*WIDTH + x` (15 bits). Write port and registered read port are independent. The store is not reset and its contents survive `rst`. A read and a write to the same address in the same cycle return the old data.
- **Plot write:** on `vga_plot=1` in state IDLE with `vga_x<WIDTH` and `vga_y<HEIGHT`, store `vga_colour` at the address.
- **Plot rejection:** a plot with out-of-range coordinates, or any plot while `busy`, is not written and increments `drop_count`.
- **Clear FSM, IDLE:** `clear=1` moves to CLEAR with address counter `ca=0`. `busy` rises the next cycle.
- **Clear FSM, CLEAR:** write 0 at `ca` every cycle and increment `ca`. After the write at `ca=WIDTH*HEIGHT-1`, return to IDLE, so `busy` is high for exactly 19200 cycles. `clear` is ignored while in CLEAR.
- **Scan divider:** `div` counts 0..PIX_DIV-1 and wraps. `tick` is asserted when `div==PIX_DIV-1`.
- **Scan counters:** on `tick`, issue a read at the current (`h`,`v`), then advance `h`. When `h` wraps from H_TOTAL-1 to 0, advance `v`. When `v` wraps from V_TOTAL-1, return to 0.
- **Scan reads:** issued whether or not a clear is running; scan-out is never stalled.
- **Output register:** one cycle after `tick`, load all outputs together:
  - `pix_x=h[7:0]` and `pix_y=v[6:0]` (the pre-advance values).
  - `pix_active=(h<WIDTH && v<HEIGHT)`.
  - `pix_colour` = read data if active, else 0.
  - `hsync_n=!(H_SYNC_START≤h<H_SYNC_START+H_SYNC_LEN)`.
  - `vsync_n=!(V_SYNC_START≤v<V_SYNC_START+V_SYNC_LEN)`.
  - `frame_start=(h==0 && v==0)`, held for that cycle only.
  - All other outputs hold between loads.

## Timing
- **Reset values:** `busy=0`, `drop_count=0`, `pix_x=0`, `pix_y=0`, `pix_colour=0`, `pix_active=0`, `frame_start=0`, `hsync_n=1`, `vsync_n=1`. Internally `div=0`, `h=0`, `v=0`, FSM=IDLE.
- **First scan output:** first `tick` in cycle PIX_DIV-1 after `rst` falls (cycle 0 = first cycle with `rst=0`). Pixel (0,0) with `frame_start=1` is presented in cycle PIX_DIV.
- **Write-to-scan latency:** a plot written in cycle N is visible to any read issued in cycle N+1 or later.
- **Frame period:** H_TOTAL·V_TOTAL·PIX_DIV cycles; `frame_start` pulses are exactly that far apart.
- **Reset mid-clear:** FSM returns to IDLE and `busy=0` the next cycle. Entries already cleared stay 0 and the rest are unchanged.
- **`clear` and `vga_plot` in the same IDLE cycle:** the plot is written, then clear begins. A later clear overwrites it.
- **Counter saturation:** `drop_count` at 0xFFFF stays there.

## Test plan
1. **Write then scan:** reset, plot (5,3,colour 6) → in the frame scan, the output with `pix_x=5`, `pix_y=3` shows `pix_colour=6` and `pix_active=1`.
2. **Out-of-range plots:** plot (160,0) and (0,120) → `drop_count=2` and no store change. Pixel (0,0) keeps its prior value.
3. **Clear:** fill all 19200 entries with 7, pulse `clear` → `busy` high exactly 19200 cycles. 3 plots issued during busy give `drop_count=3`. The next full frame shows `pix_colour=0` for every active pixel.
4. **Sync timing:** defaults → `frame_start` first appears in cycle 4. Pulses are 104800 cycles apart. `hsync_n` is low for 12 ticks per line starting at `h=170`. `vsync_n` is low for lines 122–123.
5. **Same-address collision:** plot to (h,v) in the same cycle as the `tick` reading it → the presented pixel shows the old colour; the next frame shows the new colour.
6. **Reset mid-clear:** assert `rst` 100 cycles into a clear → `busy=0` next cycle. Entries 0..99 read 0 and entry 200 keeps its old value.

Source files
------------

// File: rtl/plot_framebuffer.sv
// Pixel-plot frame store: accepts plot writes, scans the store out in raster
// order with sync timing, and blanks the store on request.
module plot_framebuffer #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 120,
  parameter int H_TOTAL      = 200,
  parameter int V_TOTAL      = 131,
  parameter int H_SYNC_START = 170,
  parameter int H_SYNC_LEN   = 12,
  parameter int V_SYNC_START = 122,
  parameter int V_SYNC_LEN   = 2,
  parameter int PIX_DIV      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clear,
  output logic        busy,
  output logic [15:0] drop_count,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [2:0]  pix_colour,
  output logic        pix_active,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = $clog2(PIX_DIV);
  localparam int HW    = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW    = ($clog2(V_TOTAL) > 7) ? $clog2(V_TOTAL) : 7;

  typedef enum logic [0:0] {
    S_IDLE,
    S_CLEAR
  } state_t;

  // ---------------------------------------------------------------- store
  logic [2:0]    mem [DEPTH];

  // ---------------------------------------------------------- clear FSM
  state_t        state_reg, state_next;
  logic [AW-1:0] ca_reg, ca_next;

  logic          in_range;
  logic [AW-1:0] plot_addr;
  logic          plot_ok;
  logic          plot_drop;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;

  logic [15:0]   drop_count_reg;

  assign in_range  = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
  assign plot_addr = AW'(int'(vga_y) * WIDTH + int'(vga_x));
  assign plot_ok   = vga_plot && (state_reg == S_IDLE) && in_range;
  assign plot_drop = vga_plot && !plot_ok;

  always_comb begin
    state_next = state_reg;
    ca_next    = ca_reg;
    case (state_reg)
      S_IDLE: begin
        if (clear) begin
          state_next = S_CLEAR;
          ca_next    = '0;
        end
      end
      S_CLEAR: begin
        if (ca_reg == AW'(DEPTH - 1)) begin
          state_next = S_IDLE;
          ca_next    = '0;
        end else begin
          ca_next = ca_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        ca_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ca_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ca_reg    <= ca_next;
    end
  end

  // Clearing and plotting never overlap: plots are only accepted in IDLE.
  // Nothing is written while rst is held so an interrupted clear stops cleanly.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = plot_addr;
    wr_data = vga_colour;
    if (!rst) begin
      if (state_reg == S_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = ca_reg;
        wr_data = 3'd0;
      end else if (plot_ok) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_reg <= '0;
    end else if (plot_drop && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  // ------------------------------------------------------------ scan-out
  logic [DW-1:0] div_reg;
  logic          tick;
  logic [HW-1:0] h_reg, h_next;
  logic [VW-1:0] v_reg, v_next;

  logic          scan_active;
  logic          scan_hsync;
  logic          scan_vsync;
  logic [AW-1:0] scan_addr;

  assign tick = (div_reg == DW'(PIX_DIV - 1));

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (tick) begin
      if (h_reg == HW'(H_TOTAL - 1)) begin
        h_next = '0;
        v_next = (v_reg == VW'(V_TOTAL - 1)) ? '0 : v_reg + 1'b1;
      end else begin
        h_next = h_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      h_reg   <= '0;
      v_reg   <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      h_reg   <= h_next;
      v_reg   <= v_next;
    end
  end

  assign scan_active = (int'(h_reg) < WIDTH) && (int'(v_reg) < HEIGHT);
  assign scan_hsync  = (int'(h_reg) >= H_SYNC_START) &&
                       (int'(h_reg) < H_SYNC_START + H_SYNC_LEN);
  assign scan_vsync  = (int'(v_reg) >= V_SYNC_START) &&
                       (int'(v_reg) < V_SYNC_START + V_SYNC_LEN);
  // Blanking positions read entry 0 so the read address always stays in range.
  assign scan_addr   = scan_active ? AW'(int'(v_reg) * WIDTH + int'(h_reg)) : '0;

  // ------------------------------------------------------ output register
  logic [7:0] pix_x_reg;
  logic [6:0] pix_y_reg;
  logic [2:0] pix_colour_reg;
  logic       pix_active_reg;
  logic       hsync_n_reg;
  logic       vsync_n_reg;
  logic       frame_start_reg;

  // The registered read of the store doubles as the colour output register,
  // so the read data and its scan position land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_colour_reg <= 3'd0;
    end else if (tick) begin
      pix_colour_reg <= scan_active ? mem[scan_addr] : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      pix_active_reg  <= 1'b0;
      hsync_n_reg     <= 1'b1;
      vsync_n_reg     <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= tick && (h_reg == '0) && (v_reg == '0);
      if (tick) begin
        pix_x_reg      <= h_reg[7:0];
        pix_y_reg      <= v_reg[6:0];
        pix_active_reg <= scan_active;
        hsync_n_reg    <= !scan_hsync;
        vsync_n_reg    <= !scan_vsync;
      end
    end
  end

  assign busy        = (state_reg == S_CLEAR);
  assign drop_count  = drop_count_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign pix_colour  = pix_colour_reg;
  assign pix_active  = pix_active_reg;
  assign hsync_n     = hsync_n_reg;
  assign vsync_n     = vsync_n_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer on a reduced 8x4 raster so that
// whole frames can be captured and compared quickly.
module tb_plot_framebuffer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int HT    = 12;
  localparam int VT    = 7;
  localparam int HSS   = 9;
  localparam int HSL   = 2;
  localparam int VSS   = 5;
  localparam int VSL   = 1;
  localparam int PD    = 2;
  localparam int FRAME = HT * VT * PD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic        clear = 1'b0;
  logic        busy;
  logic [15:0] drop_count;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;
  logic        pix_active;
  logic        hsync_n;
  logic        vsync_n;
  logic        frame_start;

  plot_framebuffer #(
    .WIDTH(W), .HEIGHT(H), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .PIX_DIV(PD)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .clear(clear), .busy(busy), .drop_count(drop_count),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_active(pix_active),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int fs_cyc = 0;

  logic [2:0] cap     [W*H];
  logic [2:0] exp_mem [W*H];
  bit         exp_valid [W*H];

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    bit          ok;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout: got no pulse, expected one within %0d cycles", 2 * FRAME);
    end
  endtask

  // Walks one whole frame from its frame_start, recording the active pixels.
  task automatic capture_frame(input bit chk);
    bit ok;
    int h, v;
    logic [31:0] act, exp;
    wait_fs(ok);
    if (ok) begin
      fs_cyc = cyc;
      for (int k = 0; k < HT * VT; k++) begin
        h = k % HT;
        v = k / HT;
        if (h < W && v < H) cap[v * W + h] = pix_colour;
        if (chk) begin
          act = 32'({pix_x, pix_y, pix_active, hsync_n, vsync_n, frame_start});
          exp = 32'({8'(h), 7'(v), (h < W && v < H),
                     !(h >= HSS && h < HSS + HSL), !(v >= VSS && v < VSS + VSL), k == 0});
          check($sformatf("scan_timing h=%0d v=%0d", h, v), act, exp);
          if (!(h < W && v < H))
            check($sformatf("blank_colour h=%0d v=%0d", h, v), 32'(pix_colour), 32'(0));
        end
        if (k != HT * VT - 1) repeat (PD) @(negedge clk);
      end
    end
  endtask

  task automatic compare_frame(input string name);
    for (int i = 0; i < W * H; i++) begin
      if (exp_valid[i])
        check($sformatf("%s x=%0d y=%0d", name, i % W, i / W), 32'(cap[i]), 32'(exp_mem[i]));
    end
  endtask

  task automatic set_all(input logic [2:0] c);
    for (int i = 0; i < W * H; i++) begin
      exp_mem[i]   = c;
      exp_valid[i] = 1'b1;
    end
  endtask

  task automatic fill(input logic [2:0] c);
    for (int a = 0; a < W * H; a++) begin
      @(negedge clk);
      vga_plot   = 1'b1;
      vga_x      = 8'(a % W);
      vga_y      = 7'(a / W);
      vga_colour = c;
    end
    @(negedge clk);
    vga_plot = 1'b0;
  endtask

  task automatic wait_not_busy(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 4 * W * H) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  initial begin
    int t0;
    int n;
    int k;
    logic [15:0] exp_drop;

    vecs[0] = '{8'd5,   7'd3,   3'd6, 1'b1, 16'd0};
    vecs[1] = '{8'd0,   7'd0,   3'd5, 1'b1, 16'd0};
    vecs[2] = '{8'd8,   7'd0,   3'd1, 1'b0, 16'd1};
    vecs[3] = '{8'd0,   7'd4,   3'd2, 1'b0, 16'd2};
    vecs[4] = '{8'd7,   7'd3,   3'd3, 1'b1, 16'd2};
    vecs[5] = '{8'd9,   7'd1,   3'd4, 1'b0, 16'd3};
    vecs[6] = '{8'd255, 7'd127, 3'd7, 1'b0, 16'd4};
    vecs[7] = '{8'd7,   7'd0,   3'd1, 1'b1, 16'd4};
    vecs[8] = '{8'd0,   7'd3,   3'd4, 1'b1, 16'd4};

    // Reset state and first scan output
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({busy, pix_x, pix_y, pix_colour, pix_active, frame_start, hsync_n, vsync_n}),
          32'({1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}));
    check("reset_drop_count", 32'(drop_count), 32'(0));
    rst = 1'b0;
    repeat (PD - 1) @(negedge clk);
    check("frame_start_early", 32'(frame_start), 32'(0));
    @(negedge clk);
    check("first_pixel", 32'({frame_start, pix_x, pix_y, pix_active}),
          32'({1'b1, 8'd0, 7'd0, 1'b1}));
    t0 = cyc;

    // Full-frame sync/position timing and frame period
    capture_frame(1'b1);
    check("frame_period", 32'(fs_cyc - t0), 32'(FRAME));

    // Fill with 7, then clear with plots rejected while busy
    fill(3'd7);
    check("fill_no_drops", 32'(drop_count), 32'(0));
    capture_frame(1'b0);
    set_all(3'd7);
    compare_frame("filled");

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("busy_rise", 32'(busy), 32'(1));
    n = 0;
    while (busy === 1'b1 && n < 4 * W * H) begin
      n++;
      if (n >= 2 && n <= 4) begin
        vga_plot = 1'b1; vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd3;
      end else begin
        vga_plot = 1'b0;
      end
      @(negedge clk);
    end
    vga_plot = 1'b0;
    check("busy_length", 32'(n), 32'(W * H));
    check("drops_while_busy", 32'(drop_count), 32'(3));
    capture_frame(1'b0);
    set_all(3'd0);
    compare_frame("cleared");

    // Table of plots, in and out of range
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("drop_after_rst", 32'(drop_count), 32'(0));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vga_plot = 1'b1; vga_x = vecs[i].x; vga_y = vecs[i].y; vga_colour = vecs[i].c;
      @(negedge clk);
      vga_plot = 1'b0;
      check($sformatf("drop_after_vec%0d", i), 32'(drop_count), 32'(vecs[i].exp_drop));
      if (vecs[i].ok) exp_mem[int'(vecs[i].y) * W + int'(vecs[i].x)] = vecs[i].c;
    end
    exp_drop = 16'd4;
    capture_frame(1'b0);
    compare_frame("table");

    // Plot landing in the same cycle as the tick that reads it, and one cycle before
    begin
      bit ok;
      wait_fs(ok);
      if (ok) begin
        k = HT + 3;
        repeat (k * PD - 1) @(negedge clk);
        vga_plot = 1'b1; vga_x = 8'd3; vga_y = 7'd1; vga_colour = 3'd5;
        @(negedge clk);
        check("collision_old", 32'({pix_x, pix_y, pix_colour}), 32'({8'd3, 7'd1, 3'd0}));
        vga_x = 8'd4; vga_colour = 3'd6;
        @(negedge clk);
        vga_plot = 1'b0;
        @(negedge clk);
        check("prior_cycle_new", 32'({pix_x, pix_y, pix_colour}), 32'({8'd4, 7'd1, 3'd6}));
      end
    end
    exp_mem[1 * W + 3] = 3'd5;
    exp_mem[1 * W + 4] = 3'd6;
    capture_frame(1'b0);
    compare_frame("collision_next");
    check("collision_no_drop", 32'(drop_count), 32'(exp_drop));

    // Plot and clear in the same IDLE cycle
    @(negedge clk);
    vga_plot = 1'b1; vga_x = 8'd2; vga_y = 7'd2; vga_colour = 3'd7; clear = 1'b1;
    @(negedge clk);
    vga_plot = 1'b0; clear = 1'b0;
    check("plot_with_clear_busy", 32'(busy), 32'(1));
    check("plot_with_clear_no_drop", 32'(drop_count), 32'(exp_drop));
    wait_not_busy("clear2_done");
    capture_frame(1'b0);
    set_all(3'd0);
    compare_frame("after_clear2");

    // Reset ten cycles into a clear
    fill(3'd7);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_rst", 32'(busy), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < W * H; i++) begin
      exp_mem[i]   = (i < 10) ? 3'd0 : 3'd7;
      exp_valid[i] = (i != 10);
    end
    capture_frame(1'b0);
    compare_frame("partial_clear");

    // Drop counter saturation
    @(negedge clk);
    vga_plot = 1'b1; vga_x = 8'd255; vga_y = 7'd0;
    repeat (65534) @(negedge clk);
    check("drop_near_sat", 32'(drop_count), 32'(16'hFFFE));
    @(negedge clk);
    check("drop_sat", 32'(drop_count), 32'(16'hFFFF));
    repeat (2) @(negedge clk);
    check("drop_sat_hold", 32'(drop_count), 32'(16'hFFFF));
    vga_plot = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
